dbus_arbiter: RTL and testbench

- Shares the single downstream data bus (dmem request/response, addr_ok/data_ok handshake) between two upstream masters: requester 0 is the commit-stage load/store path, requester 1 is the write-back/uncached store buffer.
- Grants round-robin and holds a grant until the downstream accepts the address.
- Tracks accepted-but-unanswered transactions in an ID FIFO, so each data_ok and its read data return to the requester that issued the transaction.
- Sits between the commit stage and the dcache/bridge.

---
 rtl/dbus_arbiter.sv | 153 +++++++++++++++
 tb/tb_dbus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one downstream data bus between two masters,
// with an ID FIFO that routes each response back to the requester that issued it.
module dbus_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       up_req,
    input  logic [1:0]       up_is_write,
    input  logic [1:0][31:0] up_addr,
    input  logic [1:0][31:0] up_data,
    input  logic [1:0][1:0]  up_size,
    input  logic [1:0][3:0]  up_write_en,
    output logic [1:0]       up_addr_ok,
    output logic [1:0]       up_data_ok,
    output logic [31:0]      up_rdata,
    output logic             dn_req,
    output logic             dn_is_write,
    output logic [31:0]      dn_addr,
    output logic [31:0]      dn_data,
    output logic [1:0]       dn_size,
    output logic [3:0]       dn_write_en,
    input  logic             dn_addr_ok,
    input  logic             dn_data_ok,
    input  logic [31:0]      dn_rdata,
    output logic             busy
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic               g_q, g_d;
    logic               last_g_q, last_g_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [MAX_OUT-1:0] fifo_q, fifo_d;

    logic sel;
    logic grant;
    logic accept;
    logic pop;
    logic full;
    logic head;

    // Full is judged on the registered count, so a same-cycle pop never opens a slot early.
    assign full = (count_q == CNT_W'(MAX_OUT));
    assign head = fifo_q[rd_ptr_q];
    assign pop  = dn_data_ok && (count_q != '0);

    always_comb begin
        sel     = g_q;
        grant   = 1'b0;
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            IDLE: begin
                if (!full && (up_req != 2'b00)) begin
                    grant = 1'b1;
                    if (up_req == 2'b11) begin
                        sel = ~last_g_q;
                    end else begin
                        sel = up_req[1];
                    end
                    if (!dn_addr_ok) begin
                        state_d = HOLD;
                        g_d     = sel;
                    end
                end
            end
            HOLD: begin
                sel   = g_q;
                grant = up_req[g_q];
                if (!up_req[g_q] || dn_addr_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept   = grant && dn_addr_ok;
    assign last_g_d = accept ? sel : last_g_q;

    always_comb begin
        dn_req      = grant;
        dn_is_write = 1'b0;
        dn_addr     = '0;
        dn_data     = '0;
        dn_size     = '0;
        dn_write_en = '0;
        if (grant) begin
            dn_is_write = up_is_write[sel];
            dn_addr     = up_addr[sel];
            dn_data     = up_data[sel];
            dn_size     = up_size[sel];
            dn_write_en = up_write_en[sel];
        end
    end

    assign up_addr_ok = {2{accept}} & {sel, ~sel};
    assign up_data_ok = {2{pop}} & {head, ~head};
    assign up_rdata   = dn_rdata;
    assign busy       = (count_q != '0) || (state_q == HOLD);

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            g_q      <= 1'b0;
            last_g_q <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fifo_q   <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_g_q <= last_g_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter against a queue-based model of grants,
// held requests and in-order response routing.
module tb_dbus_arbiter;

    localparam int MAX_OUT = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       up_req;
    logic [1:0]       up_is_write;
    logic [1:0][31:0] up_addr;
    logic [1:0][31:0] up_data;
    logic [1:0][1:0]  up_size;
    logic [1:0][3:0]  up_write_en;
    logic [1:0]       up_addr_ok;
    logic [1:0]       up_data_ok;
    logic [31:0]      up_rdata;
    logic             dn_req;
    logic             dn_is_write;
    logic [31:0]      dn_addr;
    logic [31:0]      dn_data;
    logic [1:0]       dn_size;
    logic [3:0]       dn_write_en;
    logic             dn_addr_ok;
    logic             dn_data_ok;
    logic [31:0]      dn_rdata;
    logic             busy;

    int testsRun    = 0;
    int testsFailed = 0;

    int   idQueue[$];
    int   heldReq;
    int   lastGrant;
    logic [1:0] pending;

    dbus_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .up_req     (up_req),
        .up_is_write(up_is_write),
        .up_addr    (up_addr),
        .up_data    (up_data),
        .up_size    (up_size),
        .up_write_en(up_write_en),
        .up_addr_ok (up_addr_ok),
        .up_data_ok (up_data_ok),
        .up_rdata   (up_rdata),
        .dn_req     (dn_req),
        .dn_is_write(dn_is_write),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .dn_size    (dn_size),
        .dn_write_en(dn_write_en),
        .dn_addr_ok (dn_addr_ok),
        .dn_data_ok (dn_data_ok),
        .dn_rdata   (dn_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic void resetModel();
        idQueue.delete();
        heldReq   = -1;
        lastGrant = 1;
    endfunction

    // One cycle: drive inputs at the negedge, compare against the model, advance the model.
    task automatic applyStimulus(input int pReq, input int pAok, input int pDok, input int pDrop);
        int  sel;
        bit  expReq;
        bit  accept;
        bit  pop;
        bit  expBusy;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!pending[i] && chance(pReq)) begin
                pending[i]     = 1'b1;
                up_addr[i]     = $urandom;
                up_data[i]     = $urandom;
                up_size[i]     = 2'($urandom_range(2));
                up_write_en[i] = 4'($urandom);
                up_is_write[i] = 1'($urandom);
            end
        end
        if (heldReq >= 0 && chance(pDrop)) pending[heldReq] = 1'b0;
        up_req     = pending;
        dn_addr_ok = chance(pAok);
        dn_data_ok = chance(pDok);
        dn_rdata   = $urandom;
        #1;

        sel     = 0;
        expReq  = 1'b0;
        expBusy = (idQueue.size() != 0) || (heldReq >= 0);
        if (heldReq >= 0) begin
            sel    = heldReq;
            expReq = up_req[heldReq];
        end else if (idQueue.size() < MAX_OUT && up_req != 2'b00) begin
            expReq = 1'b1;
            if (up_req == 2'b11) sel = 1 - lastGrant;
            else                 sel = up_req[1] ? 1 : 0;
        end
        accept = expReq && dn_addr_ok;
        pop    = dn_data_ok && (idQueue.size() > 0);

        checkOutput("dn_req",      64'(dn_req),      64'(expReq));
        checkOutput("dn_addr",     64'(dn_addr),     expReq ? 64'(up_addr[sel]) : 64'd0);
        checkOutput("dn_data",     64'(dn_data),     expReq ? 64'(up_data[sel]) : 64'd0);
        checkOutput("dn_size",     64'(dn_size),     expReq ? 64'(up_size[sel]) : 64'd0);
        checkOutput("dn_write_en", 64'(dn_write_en), expReq ? 64'(up_write_en[sel]) : 64'd0);
        checkOutput("dn_is_write", 64'(dn_is_write), expReq ? 64'(up_is_write[sel]) : 64'd0);
        checkOutput("up_addr_ok",  64'(up_addr_ok),  accept ? 64'(sel == 1 ? 2 : 1) : 64'd0);
        checkOutput("up_data_ok",  64'(up_data_ok),  pop ? 64'(idQueue[0] == 1 ? 2 : 1) : 64'd0);
        if (pop) checkOutput("up_rdata", 64'(up_rdata), 64'(dn_rdata));
        checkOutput("busy",        64'(busy),        64'(expBusy));

        if (pop) void'(idQueue.pop_front());
        if (accept) begin
            idQueue.push_back(sel);
            lastGrant    = sel;
            heldReq      = -1;
            pending[sel] = 1'b0;
        end else if (expReq) begin
            heldReq = sel;
        end else begin
            heldReq = -1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset      = 1'b1;
        pending    = 2'b00;
        up_req     = 2'b00;
        dn_addr_ok = 1'b0;
        dn_data_ok = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        resetModel();
    endtask

    initial begin
        reset       = 1'b1;
        pending     = 2'b00;
        up_req      = 2'b00;
        up_is_write = '0;
        up_addr     = '0;
        up_data     = '0;
        up_size     = '0;
        up_write_en = '0;
        dn_addr_ok  = 1'b0;
        dn_data_ok  = 1'b0;
        dn_rdata    = '0;
        resetModel();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset, then stray responses with nothing outstanding
        repeat (3) applyStimulus(0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 100, 0);

        // Both masters always requesting with an eager downstream: strict alternation
        repeat (40) applyStimulus(100, 100, 100, 0);

        // Slow address acceptance exercises grant hold
        repeat (200) applyStimulus(70, 25, 40, 0);

        // No responses: fill the FIFO and stall, then drain one slot at a time
        repeat (12) applyStimulus(100, 100, 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(100, 100, 100, 0);
            repeat (3) applyStimulus(100, 100, 0, 0);
        end

        // Fully random traffic including occasional protocol-violating drops
        repeat (1000) applyStimulus(50, 50, 50, 10);

        // Reset with work outstanding, then stray responses must be ignored
        repeat (8) applyStimulus(100, 40, 0, 0);
        doReset();
        repeat (4) applyStimulus(0, 0, 100, 0);
        repeat (300) applyStimulus(60, 60, 60, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
